// File: rtl/pipe_multiplier.sv
// Pipelined signed multiplier with accumulate and valid/ready flow control.
// Build option MULT_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module pipe_multiplier #(
    parameter int A_W    = 8,
    parameter int B_W    = 8,
    parameter int OUT_W  = 24,
    parameter int STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    input  logic                    acc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] result,
    output logic                    overflow
);

    localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic                    slot_valid [STAGES];
    logic                    slot_acc   [STAGES];
    logic signed [OUT_W-1:0] slot_prod  [STAGES];

    logic signed [A_W+B_W-1:0] prod_full;
    logic signed [OUT_W-1:0]   prod_ext;
    logic signed [OUT_W-1:0]   addend;
    logic signed [OUT_W:0]     sum;
    logic                      sum_ovf;
    logic signed [OUT_W-1:0]   next_result;
    logic signed [OUT_W-1:0]   result_reg;
    logic                      out_valid_r;
    logic                      overflow_r;
    logic                      stall;

    assign stall    = out_valid_r & ~out_ready;
    assign in_ready = ~stall;

    assign prod_full = a * b;
    assign prod_ext  = OUT_W'(prod_full);

    assign addend  = slot_acc[STAGES-1] ? result_reg : '0;
    assign sum     = (OUT_W+1)'(addend) + (OUT_W+1)'(slot_prod[STAGES-1]);
    assign sum_ovf = sum[OUT_W] ^ sum[OUT_W-1];

    always_comb begin
        next_result = sum[OUT_W-1:0];
`ifdef MULT_SAT_EN
        if (sum_ovf) begin
            next_result = sum[OUT_W] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

    // The whole pipe freezes on a stall; bubbles travel as invalid slots.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                slot_valid[i] <= 1'b0;
                slot_acc[i]   <= 1'b0;
                slot_prod[i]  <= '0;
            end
            out_valid_r <= 1'b0;
            result_reg  <= '0;
            overflow_r  <= 1'b0;
        end else if (!stall) begin
            slot_valid[0] <= in_valid;
            slot_acc[0]   <= acc;
            slot_prod[0]  <= prod_ext;
            for (int i = 1; i < STAGES; i++) begin
                slot_valid[i] <= slot_valid[i-1];
                slot_acc[i]   <= slot_acc[i-1];
                slot_prod[i]  <= slot_prod[i-1];
            end
            out_valid_r <= slot_valid[STAGES-1];
            if (slot_valid[STAGES-1]) begin
                result_reg <= next_result;
                overflow_r <= sum_ovf;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign result    = result_reg;
    assign overflow  = overflow_r;

endmodule

// File: doc/pipe_multiplier.md
# pipe_multiplier

Parametrised, pipelined signed multiplier with an optional accumulate mode and valid/ready flow control. It is the successor to the fixed 8x8, single-register multiplier in the datapath: operand widths, output width and pipeline depth are generic, and results are back-pressurable. It sits between operand sources (sample buffers, coefficient ROMs) and downstream filter/accumulation logic.

## Interface
- A_W, 8, signed width of operand a.
- B_W, 8, signed width of operand b.
- OUT_W, 24, signed result width; must satisfy OUT_W >= A_W+B_W.
- STAGES, 2, pipeline depth in cycles, legal range 1..4.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset is asynchronous and active-high; despite the name, 1 = reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  A_W  signed operand.
- b  in  B_W  signed operand.
- acc  in  1  accumulate flag for this beat; 1 = add to previous result, 0 = start fresh.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result this cycle.
- result  out  OUT_W  signed result.
- overflow  out  1  signed overflow occurred forming this result; qualified by out_valid.

## Operation
- Pipeline of STAGES register slots, each holding valid bit, product/operands and acc flag.
- Stage 1 captures a*b, full-precision signed, sign-extended to OUT_W.
- Final stage forms sum = (acc ? result_reg : 0) + product, in OUT_W+1 bits; result_reg <= sum[OUT_W-1:0].
- result_reg is the accumulator: it holds the last emitted result and updates only when a valid beat enters the final slot.
- overflow = sum[OUT_W] != sum[OUT_W-1]; never set when acc=0, because OUT_W >= A_W+B_W.
- Stall: stall = out_valid & ~out_ready. While stall is high, no slot advances, result and overflow hold, and in_ready = 0.
- in_ready = ~stall; an input beat is accepted on in_valid & in_ready.
- Bubbles (in_valid=0) propagate as invalid slots. Slots are not compacted during a stall; the stall freezes the whole pipe.
- Invalid beats never modify result_reg.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, overflow=0, all slot valid bits 0, result_reg=0.
- Reset mid-operation drops all in-flight beats immediately (asynchronous); the first accepted beat after release returns after STAGES cycles.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES, provided there is no stall.
- Throughput: one beat per cycle when out_ready=1 continuously.
- A result is held stable while out_valid=1 and out_ready=0.
- in_ready is combinational from out_valid and out_ready only; there is no path from in_valid.
- With acc=1 on consecutive beats, each beat accumulates onto the immediately preceding valid result, whatever bubbles lie between them.

## Configuration
- MULT_SAT_EN defined: on overflow, result_reg saturates to +2^(OUT_W-1)-1 or -2^(OUT_W-1) according to sum[OUT_W], and overflow=1.
- MULT_SAT_EN undefined: result wraps modulo 2^OUT_W, and overflow=1 flags the wrap.

## Test plan
- Reset and single beat: assert rst_n, release, then send a=-128, b=-128, acc=0 -> result=16384, overflow=0, out_valid high exactly STAGES cycles after acceptance.
- Streaming: 16 back-to-back beats with out_ready=1 (a=i, b=3) -> results 0,3,...,45 in order, one per cycle, in_ready stays 1.
- Backpressure: drop out_ready for 5 cycles mid-stream -> in_ready=0 during the stall, result is held, no beat is lost or duplicated, and order is preserved.
- Accumulate: beats (5,4,acc=0), (2,3,acc=1), bubble, (-1,10,acc=1) -> results 20, 26, 16.
- Overflow with OUT_W=16, A_W=B_W=8: repeat 127*127 with acc=1 -> the third result (48387) overflows; with MULT_SAT_EN it reads 32767 and overflow=1, without it it reads -17149 and overflow=1.
- Reset mid-stream: assert rst_n with 2 beats in flight -> out_valid=0 and result=0 immediately, and those beats never appear.
